// File: rtl/type_pkg.sv
// rtl/type_pkg.sv - shared classification types for the bank timing controller
package type_pkg;

  // Row storage in the open-row table is sized for the widest supported row address.
  localparam int ROW_W_MAX = 16;

  typedef enum logic [1:0] {
    OPEN_PAGE_SAME_WE = 2'd0,
    OPEN_PAGE_DIF_WE  = 2'd1,
    CLOSED_PAGE       = 2'd2,
    CROSS_PAGE        = 2'd3
  } priority_t;

  typedef struct packed {
    logic                 open_vld;
    logic [ROW_W_MAX-1:0] open_row;
  } bank_state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/page_classifier.sv
// rtl/page_classifier.sv - combinational page-hit classification of one candidate
module page_classifier
  import type_pkg::*;
#(
  parameter int ROW_W  = 3,
  parameter int BANK_W = 2
) (
  input  logic                           valid,
  input  logic [ROW_W-1:0]               row,
  input  logic [BANK_W-1:0]              bank,
  input  logic                           we,
  input  bank_state_t [2**BANK_W-1:0]    bank_table,
  input  logic                           last_we,
  output priority_t                      cls
);

  bank_state_t entry;

  always_comb begin
    entry = bank_table[bank];
    cls   = CROSS_PAGE;
    if (valid) begin
      if (!entry.open_vld) begin
        cls = CLOSED_PAGE;
      end else if (entry.open_row == ROW_W_MAX'(row)) begin
        cls = (we == last_we) ? OPEN_PAGE_SAME_WE : OPEN_PAGE_DIF_WE;
      end
    end
  end

endmodule

// File: rtl/bank_timing_control.sv
// rtl/bank_timing_control.sv - per-bank open-row tracking, busy timers and bus turnaround
module bank_timing_control
  import type_pkg::*;
#(
  parameter int ROW_W  = 3,
  parameter int BANK_W = 2,
  parameter int T_RP   = 3,
  parameter int T_RCD  = 2,
  parameter int T_WTR  = 4,
  parameter int T_RTW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read_valid,
  input  logic [ROW_W-1:0]  read_row,
  input  logic [BANK_W-1:0] read_bank,
  input  logic              write_valid,
  input  logic [ROW_W-1:0]  write_row,
  input  logic [BANK_W-1:0] write_bank,
  input  logic              read_issued,
  input  logic              write_issued,
  input  logic [ROW_W-1:0]  issue_row,
  input  logic [BANK_W-1:0] issue_bank,
  input  logic              precharge_all,
  output priority_t         read_priority,
  output priority_t         write_priority,
  output logic              read_ready,
  output logic              write_ready
);

  localparam int NUM_BANKS = 2**BANK_W;
  localparam int BUSY_W    = $clog2(T_RP + T_RCD + 1);
  localparam int TURN_W    = $clog2(max_int(T_WTR, T_RTW) + 1);

  bank_state_t [NUM_BANKS-1:0] bank_table;
  logic [BUSY_W-1:0]           bank_busy [NUM_BANKS];
  logic                        last_we;
  logic [TURN_W-1:0]           turn_cnt;
  logic                        turn_blocks_read;

  priority_t         read_cls;
  priority_t         write_cls;
  logic              issue;
  logic              issue_we;
  logic              issue_hit;
  logic [BUSY_W-1:0] issue_delay;
  bank_state_t       issue_entry;

  page_classifier #(.ROW_W(ROW_W), .BANK_W(BANK_W)) u_read_cls (
    .valid(read_valid), .row(read_row), .bank(read_bank), .we(1'b0),
    .bank_table(bank_table), .last_we(last_we), .cls(read_cls)
  );

  page_classifier #(.ROW_W(ROW_W), .BANK_W(BANK_W)) u_write_cls (
    .valid(write_valid), .row(write_row), .bank(write_bank), .we(1'b1),
    .bank_table(bank_table), .last_we(last_we), .cls(write_cls)
  );

  // A simultaneous read and write issue is a scheduler fault; the read takes effect.
  always_comb begin
    issue       = read_issued || write_issued;
    issue_we    = write_issued && !read_issued;
    issue_entry = bank_table[issue_bank];
    issue_hit   = issue_entry.open_vld && (issue_entry.open_row == ROW_W_MAX'(issue_row));
    issue_delay = issue_entry.open_vld ? BUSY_W'(T_RP + T_RCD) : BUSY_W'(T_RCD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        bank_table[b] <= '0;
        bank_busy[b]  <= '0;
      end
      last_we          <= 1'b0;
      turn_cnt         <= '0;
      turn_blocks_read <= 1'b0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (issue && (issue_bank == BANK_W'(b))) begin
          bank_table[b] <= '{open_vld: 1'b1, open_row: ROW_W_MAX'(issue_row)};
          if (!issue_hit) begin
            bank_busy[b] <= issue_delay;
          end else if (bank_busy[b] != '0) begin
            bank_busy[b] <= bank_busy[b] - 1'b1;
          end
        end else begin
          if (precharge_all) begin
            bank_table[b].open_vld <= 1'b0;
          end
          if (bank_busy[b] != '0) begin
            bank_busy[b] <= bank_busy[b] - 1'b1;
          end
        end
      end
      if (issue) begin
        turn_cnt         <= issue_we ? TURN_W'(T_WTR) : TURN_W'(T_RTW);
        turn_blocks_read <= issue_we;
        last_we          <= issue_we;
      end else if (turn_cnt != '0) begin
        turn_cnt <= turn_cnt - 1'b1;
      end
    end
  end

  // Outputs are computed from the pre-update state, so an issue shows up one edge later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      read_priority  <= CLOSED_PAGE;
      write_priority <= CLOSED_PAGE;
      read_ready     <= 1'b0;
      write_ready    <= 1'b0;
    end else begin
      read_priority  <= read_cls;
      write_priority <= write_cls;
      read_ready     <= read_valid && (bank_busy[read_bank] == '0) &&
                        !((turn_cnt != '0) && turn_blocks_read);
      write_ready    <= write_valid && (bank_busy[write_bank] == '0) &&
                        !((turn_cnt != '0) && !turn_blocks_read);
    end
  end

endmodule

// File: tb/tb_bank_timing_control.sv
// tb/tb_bank_timing_control.sv - scoreboard bench for bank_timing_control
module tb_bank_timing_control;

  localparam int ROW_W  = 3;
  localparam int BANK_W = 2;
  localparam int NB     = 4;
  localparam int T_RP   = 3;
  localparam int T_RCD  = 2;
  localparam int T_WTR  = 4;
  localparam int T_RTW  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              read_valid = 0, write_valid = 0;
  logic [ROW_W-1:0]  read_row = 0, write_row = 0, issue_row = 0;
  logic [BANK_W-1:0] read_bank = 0, write_bank = 0, issue_bank = 0;
  logic              read_issued = 0, write_issued = 0, precharge_all = 0;
  logic [1:0]        read_priority, write_priority;
  logic              read_ready, write_ready;

  bank_timing_control #(
    .ROW_W(ROW_W), .BANK_W(BANK_W), .T_RP(T_RP), .T_RCD(T_RCD), .T_WTR(T_WTR), .T_RTW(T_RTW)
  ) dut (
    .clk(clk), .rst(rst),
    .read_valid(read_valid), .read_row(read_row), .read_bank(read_bank),
    .write_valid(write_valid), .write_row(write_row), .write_bank(write_bank),
    .read_issued(read_issued), .write_issued(write_issued),
    .issue_row(issue_row), .issue_bank(issue_bank), .precharge_all(precharge_all),
    .read_priority(read_priority), .write_priority(write_priority),
    .read_ready(read_ready), .write_ready(write_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    int rp;
    int wp;
    int rr;
    int wr;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state: which row each bank has open and cycles left until usable.
  bit m_open[NB];
  int m_row[NB];
  int m_busy[NB];
  bit m_last_we;
  int m_turn;
  bit m_turn_blocks_read;

  function automatic void check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int classify(input bit valid, input int row, input int bank, input bit we);
    if (!valid) return 3;
    if (!m_open[bank]) return 2;
    if (m_row[bank] != row) return 3;
    return (we == m_last_we) ? 0 : 1;
  endfunction

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      m_open[b] = 0;
      m_row[b]  = 0;
      m_busy[b] = 0;
    end
    m_last_we = 0;
    m_turn = 0;
    m_turn_blocks_read = 0;
  endtask

  task automatic model_step();
    exp_t e;
    int   b;
    bit   we;
    if (rst) begin
      model_reset();
      e = '{rp: 2, wp: 2, rr: 0, wr: 0};
    end else begin
      e.rp = classify(read_valid, int'(read_row), int'(read_bank), 1'b0);
      e.wp = classify(write_valid, int'(write_row), int'(write_bank), 1'b1);
      e.rr = (read_valid && m_busy[read_bank] == 0 && !(m_turn > 0 && m_turn_blocks_read)) ? 1 : 0;
      e.wr = (write_valid && m_busy[write_bank] == 0 && !(m_turn > 0 && !m_turn_blocks_read)) ? 1 : 0;
      for (int i = 0; i < NB; i++) if (m_busy[i] > 0) m_busy[i]--;
      if (m_turn > 0) m_turn--;
      b = int'(issue_bank);
      if (read_issued || write_issued) begin
        we = !read_issued;
        if (!m_open[b]) m_busy[b] = T_RCD;
        else if (m_row[b] != int'(issue_row)) m_busy[b] = T_RP + T_RCD;
        m_turn = we ? T_WTR : T_RTW;
        m_turn_blocks_read = we;
        m_last_we = we;
      end
      if (precharge_all) for (int i = 0; i < NB; i++) m_open[i] = 0;
      if (read_issued || write_issued) begin
        m_open[b] = 1;
        m_row[b]  = int'(issue_row);
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic cyc(input bit rv, input int rrow, input int rbank,
                     input bit wv, input int wrow, input int wbank,
                     input bit ri = 0, input bit wi = 0, input int irow = 0,
                     input int ibank = 0, input bit pa = 0);
    @(negedge clk);
    rst           = 1'b0;
    read_valid    = rv;
    read_row      = ROW_W'(rrow);
    read_bank     = BANK_W'(rbank);
    write_valid   = wv;
    write_row     = ROW_W'(wrow);
    write_bank    = BANK_W'(wbank);
    read_issued   = ri;
    write_issued  = wi;
    issue_row     = ROW_W'(irow);
    issue_bank    = BANK_W'(ibank);
    precharge_all = pa;
    model_step();
  endtask

  task automatic reset_cycle();
    @(negedge clk);
    rst = 1'b1;
    model_step();
    #1;
    check("async_reset_rp", {6'd0, read_priority}, 8'd2);
    check("async_reset_wp", {6'd0, write_priority}, 8'd2);
    check("async_reset_rr", {7'd0, read_ready}, 8'd0);
    check("async_reset_wr", {7'd0, write_ready}, 8'd0);
  endtask

  task automatic expect_now(input string name, input int rp, input int wp, input int rr, input int wr);
    @(posedge clk);
    #2;
    check({name, "_rp"}, {6'd0, read_priority}, 8'(rp));
    check({name, "_wp"}, {6'd0, write_priority}, 8'(wp));
    check({name, "_rr"}, {7'd0, read_ready}, 8'(rr));
    check({name, "_wr"}, {7'd0, write_ready}, 8'(wr));
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("read_priority", {6'd0, read_priority}, 8'(e.rp));
      check("write_priority", {6'd0, write_priority}, 8'(e.wp));
      check("read_ready", {7'd0, read_ready}, 8'(e.rr));
      check("write_ready", {7'd0, write_ready}, 8'(e.wr));
    end
  end

  always @(posedge clk) begin
    assert (!(read_issued && write_issued)) else $error("read and write issued together");
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset_rp", {6'd0, read_priority}, 8'd2);
    check("reset_wp", {6'd0, write_priority}, 8'd2);
    check("reset_rr", {7'd0, read_ready}, 8'd0);
    check("reset_wr", {7'd0, write_ready}, 8'd0);

    // Closed bank candidates straight out of reset
    cyc(1, 0, 0, 1, 0, 0);
    expect_now("tp_closed", 2, 2, 1, 1);

    // Write to closed bank 1: write-to-read turnaround and activate delay
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 5, 1);
    repeat (6) cyc(1, 5, 1, 1, 5, 1);

    // Cross-page access to bank 2, then hit after the delay
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 3, 2);
    repeat (3) cyc(1, 6, 2, 1, 6, 2);
    cyc(1, 6, 2, 1, 6, 2, 1, 0, 6, 2);
    repeat (6) cyc(1, 6, 2, 1, 6, 2);
    cyc(1, 6, 2, 0, 0, 0);
    expect_now("tp_cross_done", 0, 3, 1, 0);

    // Closed bank 3, then precharge_all closes everything
    cyc(1, 1, 3, 1, 1, 3, 1, 0, 1, 3);
    repeat (3) cyc(1, 1, 3, 1, 1, 3);
    cyc(1, 1, 3, 1, 6, 2, 0, 0, 0, 0, 1);
    repeat (2) cyc(1, 1, 3, 1, 6, 2);

    // Reset in the middle of a 5-cycle busy count
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 6, 2);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 1, 2);
    cyc(1, 1, 2, 1, 1, 2);
    cyc(1, 1, 2, 1, 1, 2);
    reset_cycle();
    cyc(1, 1, 2, 1, 1, 2);
    cyc(1, 1, 2, 1, 1, 2);

    // Invalid read beside a write hit
    cyc(0, 0, 0, 0, 0, 0, 0, 1, 2, 0);
    repeat (4) cyc(0, 0, 0, 1, 2, 0);
    cyc(0, 7, 0, 1, 2, 0);
    expect_now("tp_invalid_read", 3, 0, 0, 1);

    // Randomized traffic over a small row space to provoke hits and conflicts
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        reset_cycle();
      end else begin
        kind = $urandom_range(0, 3);
        cyc($urandom_range(0, 1), $urandom_range(0, 2), $urandom_range(0, 3),
            $urandom_range(0, 1), $urandom_range(0, 2), $urandom_range(0, 3),
            kind == 1, kind == 2, $urandom_range(0, 2), $urandom_range(0, 3),
            $urandom_range(0, 15) == 0);
      end
    end
    cyc(0, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    check("scoreboard_drained", 8'(exp_q.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bank_timing_control.md
# bank_timing_control

Parametrised successor to `timing_control` for the memory controller's command scheduler. It classifies the pending read and write candidates from the request pools into `priority_t` classes against a per-bank open-row table, where the previous block used a single last row and bank. It also tracks per-bank activate/precharge delays and read/write bus turnaround, so the scheduler knows each candidate's cost and whether it may issue this cycle.

## Interface
Parameters:
- `ROW_W`, 3: row address width.
- `BANK_W`, 2: bank address width; `NUM_BANKS = 2**BANK_W`.
- `T_RP`, 3: precharge cycles charged on a row conflict.
- `T_RCD`, 2: activate-to-column cycles.
- `T_WTR`, 4: write-to-read turnaround cycles.
- `T_RTW`, 2: read-to-write turnaround cycles.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `read_valid`  in  1  read candidate present.
- `read_row`  in  ROW_W  read candidate row.
- `read_bank`  in  BANK_W  read candidate bank.
- `write_valid`  in  1  write candidate present.
- `write_row`  in  ROW_W  write candidate row.
- `write_bank`  in  BANK_W  write candidate bank.
- `read_issued`  in  1  scheduler issued a read this cycle.
- `write_issued`  in  1  scheduler issued a write this cycle.
- `issue_row`  in  ROW_W  row of the issued command.
- `issue_bank`  in  BANK_W  bank of the issued command.
- `precharge_all`  in  1  close all banks (refresh entry).
- `read_priority`  out  2  `priority_t` class of the read candidate.
- `write_priority`  out  2  `priority_t` class of the write candidate.
- `read_ready`  out  1  read candidate is timing-legal.
- `write_ready`  out  1  write candidate is timing-legal.

## Operation
- State:
  - per bank: `open_vld`, `open_row`, down-counter `bank_busy`;
  - globally: `last_we` (1 = last issue was a write), down-counter `turn_cnt`, `turn_blocks_read` flag.
- Classification of a candidate (row r, bank b, type we):
  - `open_vld[b]` and `open_row[b]==r` and `we==last_we` -> OPEN_PAGE_SAME_WE (0).
  - Row matches, type differs -> OPEN_PAGE_DIF_WE (1).
  - `!open_vld[b]` -> CLOSED_PAGE (2).
  - Open with a different row -> CROSS_PAGE (3).
  - An invalid candidate reports CROSS_PAGE and not ready.
- Effects of an issue to bank b:
  - The class is computed against the pre-issue table.
  - Hit (class 0/1): `bank_busy[b]` unchanged.
  - Closed: `bank_busy[b]=T_RCD`.
  - Cross: `bank_busy[b]=T_RP+T_RCD`.
  - Table then holds `open_vld[b]=1`, `open_row[b]=issue_row`.
- Turnaround:
  - A write issue loads `turn_cnt=T_WTR`, `turn_blocks_read=1`.
  - A read issue loads `turn_cnt=T_RTW`, `turn_blocks_read=0`.
  - `last_we` updates to the issued type.
- Ready:
  - `read_ready = read_valid && bank_busy[read_bank]==0 && !(turn_cnt!=0 && turn_blocks_read)`.
  - `write_ready` is symmetric.
- Counters decrement by 1 per cycle and saturate at 0. A reload in the same cycle wins over the decrement.
- `precharge_all` clears every `open_vld`. If it coincides with an issue, the issue's table update wins for its bank only; counters are unaffected.
- `read_issued && write_issued`:
  - illegal; the read is applied and the write ignored;
  - the bench asserts this never occurs.
- Issue with `issue_bank` equal to a busy bank: applied anyway (scheduler fault) and the counter is reloaded.

## Timing
- All four outputs are registered. They reflect the inputs and state sampled at the previous rising edge, so latency is 1 cycle.
- Classification uses the table state before the same-edge issue update. Outputs therefore reflect an issue at edge N from edge N+1.
- A busy count of K holds ready low for K output cycles after the issue edge.
- Reset (asynchronous, immediate):
  - all banks closed, `last_we=0`, counters 0;
  - `read_priority=write_priority=CLOSED_PAGE`, `read_ready=write_ready=0`.
- Reset asserted mid-count discards all pending delays.

## Structure
- `type_pkg`:
  - `priority_t` (OPEN_PAGE_SAME_WE=0, OPEN_PAGE_DIF_WE=1, CLOSED_PAGE=2, CROSS_PAGE=3);
  - a `bank_state_t` struct (`open_vld`, `open_row`).
- Counter widths are `$clog2(T_RP+T_RCD+1)` and `$clog2(max(T_WTR,T_RTW)+1)`.
- Sub-module `page_classifier`: combinational, instantiated twice (read, write). Inputs are candidate row, bank, we and valid, the table, and `last_we`; output is `priority_t`.

## Test plan
- Reset, then read and write valid on bank 0 row 0 -> priorities 2/2, ready 1/1 the next cycle.
- Write issue bank 1 row 5; then read and write candidates at bank 1 row 5 -> write_priority 0, read_priority 1. `read_ready` stays low for 4 cycles (T_WTR) while `write_ready` is high after T_RCD.
- With bank 2 open at row 3, candidate bank 2 row 6 -> CROSS_PAGE. After issuing it, ready for bank 2 is low for 5 cycles, then high with class 0.
- Issue to closed bank 3 -> ready low 2 cycles. Then pulse `precharge_all` -> all candidates report CLOSED_PAGE.
- Assert `rst` 2 cycles into a 5-cycle busy count -> outputs are the reset values immediately, and ready is 1 the cycle after release.
- Invalid read candidate alongside a hit write -> read_priority 3 with read_ready 0; write is unaffected.
